// File: rtl/mul_ctrl.sv
// ---------------------------------------------------------------------------
// mul_ctrl
//
// Purpose:
//   Sequencing controller between an execute stage and a multicycle 64-bit
//   multiplier. It accepts one MUL/MULW op at a time, latches the operands,
//   issues a one-cycle start pulse, waits for the multiplier to finish,
//   formats the result (MULW sign-extends the low word) and holds it until
//   the consumer takes it. A pipeline flush squashes the in-flight op. When
//   the multiplier is in flight at flush time, its completion is drained so
//   it cannot leak into the next op. A wait counter aborts a stuck op and
//   pulses err.
//
// Configuration:
//   MUL_CTRL_ZERO_SKIP_EN (define) - an accepted op whose effective operand
//   is zero bypasses the multiplier and goes directly to HOLD with a zero
//   result. Undefined (default): every op goes through LAUNCH/WAIT.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles spent in WAIT/DRAIN before abort (70..255)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous reset, active low
//   req_valid   in   execute stage presents an op
//   req_word    in   0 = MUL (low 64 bits), 1 = MULW (sext low 32 bits)
//   req_a/b     in   64-bit operands
//   req_ready   out  op accepted this cycle when req_valid is also high
//   flush       in   pipeline squash
//   mul_valid   out  start pulse to the multiplier
//   mul_a/b     out  latched operands, stable until the next accept
//   mul_done    in   multiplier completion, mul_c valid while high
//   mul_c       in   multiplier low 64-bit product
//   resp_valid  out  result available (HOLD)
//   resp_data   out  formatted result
//   resp_ready  in   consumer takes the result
//   busy        out  controller is not IDLE
//   err         out  one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module mul_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_word,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        mul_valid,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    input  logic        resp_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    // The counter holds the number of cycles already spent in WAIT/DRAIN.
    // Timeout fires in the cycle where that count reaches TIMEOUT_CYCLES-1.
    // The abort therefore lands exactly TIMEOUT_CYCLES cycles after WAIT
    // entry.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [63:0] a_q,     a_d;
    logic [63:0] b_q,     b_d;
    logic        word_q,  word_d;
    logic [63:0] res_q,   res_d;
    logic        err_q,   err_d;

    logic        idle;
    logic        accept;
    logic        timeout;
    logic        zero_op;

    // MULW keeps only the low word of the product and sign-extends it.
    function automatic logic [63:0] fmt_result(input logic        word,
                                               input logic [63:0] c);
        logic signed [31:0] lo;
        lo = c[31:0];
        if (word) begin
            return {{32{lo[31]}}, lo};
        end
        return c;
    endfunction

`ifdef MUL_CTRL_ZERO_SKIP_EN
    // For MULW only the low 32 bits of each operand affect the result.
    function automatic logic is_zero_op(input logic        word,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
        if (word) begin
            return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
        end
        return (a == 64'd0) || (b == 64'd0);
    endfunction
`endif

    // Accept decision uses the ungated ready term. Reset already forces
    // the state register, so it is kept out of the flop data paths.
    assign idle    = (state_q == S_IDLE);
    assign accept  = req_valid && idle && !flush;
    assign timeout = (cnt_q >= TIMEOUT_LAST);

`ifdef MUL_CTRL_ZERO_SKIP_EN
    assign zero_op = is_zero_op(req_word, req_a, req_b);
`else
    assign zero_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register (all state cleared asynchronously)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            word_q  <= 1'b0;
            res_q   <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            word_q  <= word_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = zero_op ? S_HOLD : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over timeout. Completion together with
                // flush leaves nothing in flight, so no drain is needed.
                if (mul_done) begin
                    state_d = flush ? S_IDLE : S_HOLD;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The squashed op's completion is swallowed here.
                if (mul_done) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath register updates, steered by the state transition
    // ------------------------------------------------------------------
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        word_d = word_q;
        res_d  = res_q;
        cnt_d  = cnt_q;

        if (accept) begin
            a_d    = req_a;
            b_d    = req_b;
            word_d = req_word;
        end

        case (state_q)
            S_IDLE: begin
                // A bypassed op lands in HOLD with a zero result.
                if (accept && zero_op) begin
                    res_d = 64'd0;
                end
            end
            S_LAUNCH: begin
                cnt_d = 8'd0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mul_done && !flush) begin
                    res_d = fmt_result(word_q, mul_c);
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Gated by reset so every output reads zero while reset is held.
        req_ready  = idle && !flush && reset;
        mul_valid  = (state_q == S_LAUNCH) && !flush;
        resp_valid = (state_q == S_HOLD);
        busy       = !idle;
        mul_a      = a_q;
        mul_b      = b_q;
        resp_data  = res_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;
    localparam int T = 96;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_word = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        mul_valid;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_c = '0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_ready = 1'b0;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int mv_pulses = 0;
    int rv_cycles = 0;

    mul_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_word(req_word), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .flush(flush),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mul_valid === 1'b1) mv_pulses++;
        if (resp_valid === 1'b1) rv_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1; req_word = w; req_a = a; req_b = b;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (mul_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        cyc(); cyc();
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_mul();
        int p0, r0;
        p0 = mv_pulses; r0 = rv_cycles;
        issue(1'b0, 64'd3, 64'd5);
        #1;
        n_cmp++; if (mul_valid !== 1'b1) begin n_bad++; $display("FAIL mul_launch_valid: got %b want 1", mul_valid); end
        n_cmp++; if (mul_a !== 64'd3 || mul_b !== 64'd5) begin n_bad++; $display("FAIL mul_operands: got %h/%h want 3/5", mul_a, mul_b); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mul_launch_ready: got %b want 0", req_ready); end
        cyc();
        repeat (64) cyc();
        mul_done = 1'b1; mul_c = 64'd15;
        cyc();
        mul_done = 1'b0; mul_c = '1; resp_ready = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 64'd15) begin n_bad++; $display("FAIL mul_resp: got %b/%h want 1/f", resp_valid, resp_data); end
        cyc();
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mul_back_idle: got busy %b ready %b want 0 1", busy, req_ready); end
        n_cmp++; if (mv_pulses - p0 !== 1) begin n_bad++; $display("FAIL mul_pulse_count: got %0d want 1", mv_pulses - p0); end
        n_cmp++; if (rv_cycles - r0 !== 1) begin n_bad++; $display("FAIL mul_resp_cycles: got %0d want 1", rv_cycles - r0); end
    endtask

    task automatic test_mulw();
        issue(1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
        mul_done = 1'b1; mul_c = 64'hDEAD;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL mulw_done_in_launch: got busy %b rv %b want 1 0", busy, resp_valid); end
        cyc();
        mul_done = 1'b1; mul_c = 64'h0000_0000_FFFF_FFFE;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulw_neg: got %h want fffffffffffffffe", resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        issue(1'b1, 64'hFFFF_FFFF_0000_0003, 64'd5);
        cyc();
        mul_done = 1'b1; mul_c = 64'hABCD_0000_0000_000F;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (resp_data !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL mulw_pos: got %h want f", resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    task automatic test_flush_wait();
        int p0, r0;
        p0 = mv_pulses; r0 = rv_cycles;
        issue(1'b0, 64'd7, 64'd9);
        cyc();
        repeat (9) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got busy %b ready %b want 1 0", busy, req_ready); end
        repeat (3) cyc();
        mul_done = 1'b1; mul_c = 64'd63;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL drain_exit: got ready %b busy %b want 1 0", req_ready, busy); end
        cyc();
        n_cmp++; if (rv_cycles - r0 !== 0) begin n_bad++; $display("FAIL drain_no_resp: got %0d want 0", rv_cycles - r0); end
        n_cmp++; if (mv_pulses - p0 !== 1) begin n_bad++; $display("FAIL drain_pulses: got %0d want 1", mv_pulses - p0); end
    endtask

    task automatic test_flush_done();
        issue(1'b0, 64'd2, 64'd2);
        cyc();
        flush = 1'b1; mul_done = 1'b1; mul_c = 64'd4;
        cyc();
        flush = 1'b0; mul_done = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_done: got busy %b rv %b ready %b want 0 0 1", busy, resp_valid, req_ready); end
    endtask

    task automatic test_flush_launch_idle();
        issue(1'b0, 64'd1, 64'd1);
        flush = 1'b1;
        #1;
        n_cmp++; if (mul_valid !== 1'b0) begin n_bad++; $display("FAIL flush_launch_valid: got %b want 0", mul_valid); end
        cyc();
        flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_launch_idle: got %b want 0", busy); end
        flush = 1'b1; req_valid = 1'b1; req_a = 64'd5;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || mul_a !== 64'd1) begin n_bad++; $display("FAIL flush_idle_noaccept: got busy %b a %h want 0 1", busy, mul_a); end
    endtask

    task automatic test_hold_stall();
        int bad;
        bad = 0;
        issue(1'b0, 64'd6, 64'd7);
        cyc();
        mul_done = 1'b1; mul_c = 64'd42;
        cyc();
        mul_done = 1'b0; mul_c = 64'hDEAD;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (resp_valid !== 1'b1 || resp_data !== 64'd42 || req_ready !== 1'b0) bad++;
            cyc();
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        n_cmp++; if (mul_a !== 64'd6 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_after_stall: got a %h rv %b want 6 1", mul_a, resp_valid); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got busy %b ready %b want 0 1", busy, req_ready); end
        issue(1'b0, 64'd4, 64'd4);
        cyc();
        mul_done = 1'b1; mul_c = 64'd16;
        cyc();
        mul_done = 1'b0; flush = 1'b1; resp_ready = 1'b1;
        cyc();
        flush = 1'b0; resp_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_hold: got busy %b rv %b want 0 0", busy, resp_valid); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_word = 1'b0; req_a = 64'd21; req_b = 64'd2;
        cyc();
        req_a = 64'd99; req_b = 64'd3;
        cyc();
        mul_done = 1'b1; mul_c = 64'd42;
        cyc();
        mul_done = 1'b0; resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0 || mul_a !== 64'd21) begin n_bad++; $display("FAIL b2b_hold: got ready %b a %h want 0 15", req_ready, mul_a); end
        cyc();
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got %b want 1", req_ready); end
        cyc();
        req_valid = 1'b0;
        #1;
        n_cmp++; if (mul_valid !== 1'b1 || mul_a !== 64'd99) begin n_bad++; $display("FAIL b2b_second: got mv %b a %h want 1 63", mul_valid, mul_a); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic test_timeout();
        int first, highs, busy_at, r0;
        first = -1; highs = 0; busy_at = -1; r0 = rv_cycles;
        issue(1'b0, 64'd9, 64'd9);
        cyc();
        for (int k = 1; k <= T + 4; k++) begin
            cyc();
            if (err === 1'b1) begin
                highs++;
                if (first < 0) begin
                    first = k;
                    busy_at = int'(busy);
                end
            end
        end
        n_cmp++; if (first !== T) begin n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", first, T); end
        n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL timeout_pulse_len: got %0d want 1", highs); end
        n_cmp++; if (busy_at !== 0) begin n_bad++; $display("FAIL timeout_idle: got busy %0d want 0", busy_at); end
        n_cmp++; if (rv_cycles - r0 !== 0) begin n_bad++; $display("FAIL timeout_no_resp: got %0d want 0", rv_cycles - r0); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 64'd1, 64'd1);
        cyc();
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b0 || mul_valid !== 1'b0 || resp_valid !== 1'b0 || err !== 1'b0)
            begin n_bad++; $display("FAIL midrst_ctrl: got busy %b ready %b mv %b rv %b err %b want all 0", busy, req_ready, mul_valid, resp_valid, err); end
        n_cmp++; if (mul_a !== 64'd0 || mul_b !== 64'd0 || resp_data !== 64'd0)
            begin n_bad++; $display("FAIL midrst_data: got %h %h %h want 0 0 0", mul_a, mul_b, resp_data); end
        cyc(); cyc();
        reset = 1'b1;
        #1;
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        #1;
        n_cmp++; if (mul_valid !== 1'b1 || mul_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL midrst_launch: got mv %b a %h want 1 ffffffffffffffff", mul_valid, mul_a); end
        cyc();
        mul_done = 1'b1; mul_c = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL midrst_result: got %b %h want 1 fffffffffffffffe", resp_valid, resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    task automatic test_zero_op();
        int p0;
        p0 = mv_pulses;
`ifdef MUL_CTRL_ZERO_SKIP_EN
        issue(1'b0, 64'd0, 64'd5);
        #1;
        n_cmp++; if (mul_valid !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 64'd0) begin n_bad++; $display("FAIL zskip_mul: got mv %b rv %b d %h want 0 1 0", mul_valid, resp_valid, resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        issue(1'b1, 64'h0000_0001_0000_0000, 64'd3);
        #1;
        n_cmp++; if (mul_valid !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 64'd0) begin n_bad++; $display("FAIL zskip_mulw: got mv %b rv %b d %h want 0 1 0", mul_valid, resp_valid, resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        n_cmp++; if (mv_pulses - p0 !== 0) begin n_bad++; $display("FAIL zskip_pulses: got %0d want 0", mv_pulses - p0); end
`else
        issue(1'b0, 64'd0, 64'd5);
        #1;
        n_cmp++; if (mul_valid !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL zero_launch: got mv %b rv %b want 1 0", mul_valid, resp_valid); end
        cyc();
        mul_done = 1'b1; mul_c = 64'd0;
        cyc();
        mul_done = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 64'd0) begin n_bad++; $display("FAIL zero_result: got %b %h want 1 0", resp_valid, resp_data); end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        n_cmp++; if (mv_pulses - p0 !== 1) begin n_bad++; $display("FAIL zero_pulses: got %0d want 1", mv_pulses - p0); end
`endif
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulw();
        test_flush_wait();
        test_flush_done();
        test_flush_launch_idle();
        test_hold_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_zero_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 96: maximum WAIT/DRAIN cycles before abort; legal range 70-255.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a multiply op.
REQ-005 req_word  in  1  0 = MUL (64-bit low product), 1 = MULW (sign-extended low 32 bits).
REQ-006 req_a, req_b  in  64 each  operands.
REQ-007 req_ready  out  1  controller accepts request this cycle.
REQ-008 flush  in  1  pipeline squash; discards in-flight op.
REQ-009 mul_valid  out  1  start pulse to multicycle multiplier.
REQ-010 mul_a, mul_b  out  64 each  latched operands to multiplier.
REQ-011 mul_done  in  1  multiplier completion; mul_c is valid while it is high.
REQ-012 mul_c  in  64  multiplier low 64-bit product.
REQ-013 resp_valid  out  1  result available.
REQ-014 resp_data  out  64  result.
REQ-015 resp_ready  in  1  consumer accepts result.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-018 States: IDLE, LAUNCH, WAIT, HOLD, DRAIN.
REQ-019 req_ready SHALL equal (state==IDLE && !flush).
REQ-020 Accept (req_valid && req_ready): latch req_a, req_b and req_word; IDLE->LAUNCH.
REQ-021 LAUNCH lasts exactly one cycle; mul_valid = (state==LAUNCH && !flush); next state is WAIT, or IDLE if flush.
REQ-022 mul_a/mul_b SHALL hold the latched operands from LAUNCH until the next accept.
REQ-023 mul_done SHALL be ignored in IDLE, LAUNCH and HOLD; in WAIT, mul_done high -> capture result, WAIT->HOLD.
REQ-024 Captured result: MUL -> mul_c; MULW -> {32{mul_c[31]}, mul_c[31:0]}.
REQ-025 HOLD: resp_valid=1, resp_data stable; resp_ready -> IDLE next cycle. resp_valid is 0 in all other states.
REQ-026 Latency without stalls: accept at cycle T, mul_valid at T+1, and resp_valid on the cycle after mul_done is sampled in WAIT.
REQ-027 Flush in WAIT -> DRAIN. DRAIN waits for mul_done, discards it, then goes to IDLE.
REQ-028 Flush and mul_done together in WAIT -> IDLE; result discarded.
REQ-029 Flush in HOLD -> IDLE; flush takes priority over resp_ready.
REQ-030 Flush in IDLE: no request accepted; no other effect.
REQ-031 An 8-bit wait counter clears on entry to WAIT and increments each cycle in WAIT/DRAIN. Reaching TIMEOUT_CYCLES without mul_done -> IDLE with err=1 for one cycle; no response is produced.
REQ-032 No new request is accepted until IDLE is re-entered; back-to-back ops need at least one IDLE cycle.

Reset
REQ-033 reset low asynchronously forces state=IDLE, wait counter=0, mul_valid=0, resp_valid=0, err=0, and mul_a, mul_b, resp_data=0.
REQ-034 Reset mid-operation abandons the op with no response; the first accept after reset release is serviced normally.

Configuration
REQ-035 With macro MUL_CTRL_ZERO_SKIP_EN defined: an accepted op whose effective operand is zero goes IDLE->HOLD directly, with resp_data=0 on the next cycle and no mul_valid. The effective operand is the full 64 bits for MUL and the low 32 bits of either operand for MULW.
REQ-036 Without MUL_CTRL_ZERO_SKIP_EN defined: every accepted op passes through LAUNCH/WAIT.

Verification
REQ-037 MUL a=3, b=5, multiplier done after 65 cycles, resp_ready=1 -> one mul_valid pulse, resp_data=15, resp_valid for 1 cycle.
REQ-038 MULW a=0x7FFF_FFFF, b=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFE.
REQ-039 Flush in cycle 10 of WAIT -> DRAIN; mul_done consumed; resp_valid never rises; req_ready high on the cycle after DRAIN exits.
REQ-040 resp_ready held low 5 cycles in HOLD -> resp_data stable, req_ready=0 throughout; after accept, IDLE.
REQ-041 mul_done held low -> err pulse exactly TIMEOUT_CYCLES cycles after WAIT entry; state IDLE.
REQ-042 reset asserted in WAIT, then a=0xFFFF_FFFF_FFFF_FFFF, b=2 issued -> all outputs 0 during reset; result 0xFFFF_FFFF_FFFF_FFFE. With MUL_CTRL_ZERO_SKIP_EN, MUL a=0 gives resp_data=0 one cycle after accept with no mul_valid.
